// File: rtl/tm_inference_sequencer.sv
// Time-multiplexed Tsetlin Machine inference sequencer.
// A single clause evaluator walks every clause of every class, one per clock,
// accumulating a signed vote per class and keeping a running argmax. The
// winning class and its vote are returned over a valid/ready handshake.
// Exclude masks sit in a local register file written through a config port.
module tm_inference_sequencer #(
    parameter int NUM_FEATURES      = 2,
    parameter int NUM_CLASSES       = 2,
    parameter int CLAUSES_PER_CLASS = 4,
    parameter int VOTE_W            = 4
) (
    input  logic                                                  i_clk,
    input  logic                                                  i_rst,
    input  logic                                                  i_cfg_we,
    input  logic [$clog2(NUM_CLASSES*CLAUSES_PER_CLASS)-1:0]      i_cfg_addr,
    input  logic [2*NUM_FEATURES-1:0]                             i_cfg_data,
    input  logic                                                  i_in_valid,
    output logic                                                  o_in_ready,
    input  logic [NUM_FEATURES-1:0]                               i_features,
    output logic                                                  o_out_valid,
    input  logic                                                  i_out_ready,
    output logic [$clog2(NUM_CLASSES)-1:0]                        o_class_out,
    output logic signed [VOTE_W-1:0]                              o_best_vote
);

    localparam int NCL    = NUM_CLASSES * CLAUSES_PER_CLASS;
    localparam int LIT_W  = 2 * NUM_FEATURES;
    localparam int ADDR_W = $clog2(NCL);
    localparam int CLS_W  = $clog2(NUM_CLASSES);
    localparam int J_W    = $clog2(CLAUSES_PER_CLASS);
    localparam int HALF   = CLAUSES_PER_CLASS / 2;

    localparam logic [ADDR_W-1:0]        LAST_CLAUSE = ADDR_W'(NCL - 1);
    localparam logic [J_W-1:0]           LAST_J      = J_W'(CLAUSES_PER_CLASS - 1);
    localparam logic [J_W-1:0]           FIRST_NEG   = J_W'(HALF);
    localparam logic signed [VOTE_W-1:0] VOTE_MIN    = {1'b1, {(VOTE_W-1){1'b0}}};
    localparam logic signed [VOTE_W-1:0] VOTE_PLUS   = VOTE_W'(1);
    localparam logic signed [VOTE_W-1:0] VOTE_MINUS  = {VOTE_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      r_state;
    logic [NUM_FEATURES-1:0]     r_feat;
    logic [ADDR_W-1:0]           r_ctr;      // global clause index, also mask address
    logic [J_W-1:0]              r_j;        // clause index inside current class
    logic [CLS_W-1:0]            r_cls;      // class currently being accumulated
    logic signed [VOTE_W-1:0]    r_acc;
    logic signed [VOTE_W-1:0]    r_best;
    logic [CLS_W-1:0]            r_best_cls;
    logic                        r_in_ready;
    logic                        r_out_valid;
    logic [LIT_W-1:0]            r_mask [NCL];

    logic [LIT_W-1:0]            w_lits;
    logic [LIT_W-1:0]            w_mask;
    logic                        w_fire;
    logic                        w_pos;
    logic signed [VOTE_W-1:0]    w_step;
    logic signed [VOTE_W-1:0]    w_acc_next;
    logic                        w_better;

    // Shared clause evaluator: an excluded literal is forced to 1 so it drops
    // out of the AND; an all-excluded clause therefore fires.
    always_comb begin
        w_lits     = {r_feat, ~r_feat};
        w_mask     = r_mask[r_ctr];
        w_fire     = &(w_lits | w_mask);
        w_pos      = (r_j < FIRST_NEG);
        w_step     = '0;
        if (w_fire) begin
            w_step = w_pos ? VOTE_PLUS : VOTE_MINUS;
        end
        w_acc_next = r_acc + w_step;
        w_better   = (w_acc_next > r_best);
    end

    // Mask register file; frozen during EVAL so a sample sees one mask set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NCL; i++) begin
                r_mask[i] <= '1;
            end
        end else if (i_cfg_we && (r_state != S_EVAL)) begin
            r_mask[i_cfg_addr] <= i_cfg_data;
        end
    end

    // Sequencer FSM: accept, walk all clauses, hold result until consumed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_feat      <= '0;
            r_ctr       <= '0;
            r_j         <= '0;
            r_cls       <= '0;
            r_acc       <= '0;
            r_best      <= '0;
            r_best_cls  <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_feat     <= i_features;
                        r_ctr      <= '0;
                        r_j        <= '0;
                        r_cls      <= '0;
                        r_acc      <= '0;
                        r_best     <= VOTE_MIN;
                        r_best_cls <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    r_ctr <= r_ctr + 1'b1;
                    if (r_j == LAST_J) begin
                        // Class boundary: strict compare keeps the lower index on ties.
                        r_j   <= '0;
                        r_cls <= r_cls + 1'b1;
                        r_acc <= '0;
                        if (w_better) begin
                            r_best     <= w_acc_next;
                            r_best_cls <= r_cls;
                        end
                    end else begin
                        r_j   <= r_j + 1'b1;
                        r_acc <= w_acc_next;
                    end
                    if (r_ctr == LAST_CLAUSE) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_class_out = r_best_cls;
    assign o_best_vote = r_best;

endmodule

// File: doc/tm_inference_sequencer.md
Name: tm_inference_sequencer

Overview:
Time-multiplexed Tsetlin Machine inference controller. One shared clause evaluator is stepped across every clause of every class, one clause per clock. The block accumulates signed class votes and tracks a running argmax, then returns the winning class over a valid/ready handshake. Per-clause exclude masks live in an internal register file, written through a config port. This replaces the fully parallel clause array plus sum/threshold stage in the inference path.

Parameters:
NUM_FEATURES, 2, boolean features per sample; literal vector width is 2*NUM_FEATURES.
NUM_CLASSES, 2, number of classes; must be at least 2.
CLAUSES_PER_CLASS, 4, clauses per class; must be even. Local index j < CLAUSES_PER_CLASS/2 is positive polarity; the rest are negative.
VOTE_W, 4, signed vote/accumulator width; must hold ±CLAUSES_PER_CLASS/2.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
cfg_we  in  1  mask write strobe
cfg_addr  in  clog2(NUM_CLASSES*CLAUSES_PER_CLASS)  clause address = class*CLAUSES_PER_CLASS + j
cfg_data  in  2*NUM_FEATURES  exclude mask; bit=1 excludes that literal
in_valid  in  1  sample valid
in_ready  out  1  high only in IDLE
features  in  NUM_FEATURES  sample, captured on accept
out_valid  out  1  result valid
out_ready  in  1  result consumed
class_out  out  clog2(NUM_CLASSES)  winning class
best_vote  out  VOTE_W  signed vote of the winning class

Behaviour:
- Literals = {features, ~features}. Literal bit i is in the clause iff mask bit i = 0. Clause = AND of included literals; an all-excluded clause outputs 1.
- Class vote = (count of firing positive clauses) − (count of firing negative clauses), two's complement.
- States:
  - IDLE: in_ready=1.
  - EVAL: processes one clause per cycle.
  - DONE: out_valid=1.
- IDLE→EVAL on in_valid&&in_ready. On that edge: capture features, clear clause counter and vote accumulator, set best_vote to the most-negative value and class_out to 0.
- EVAL, each cycle: evaluate clause[ctr] and add ±1 to the accumulator.
  - On the last clause of class k, compare the final class vote to best. Update best_vote/class_out only if strictly greater (ties keep the lower class index). Clear the accumulator for class k+1.
  - After clause NUM_CLASSES*CLAUSES_PER_CLASS−1, go to DONE.
- Latency: out_valid rises exactly NUM_CLASSES*CLAUSES_PER_CLASS cycles after the accept edge (8 at defaults).
- DONE: class_out and best_vote are held stable while out_valid=1. On out_valid&&out_ready, go to IDLE. Earliest next accept is the cycle after that.
- in_valid in EVAL or DONE is not accepted (in_ready=0). Upstream must hold it.
- Config writes take effect next cycle in IDLE and DONE. A cfg_we in EVAL is ignored (mask unchanged), so in-flight results always use a consistent mask set.
- Reset (any state, including mid-EVAL):
  - State→IDLE, out_valid=0, class_out=0, best_vote=0, counters=0.
  - All masks→all-ones, i.e. every clause fires and every vote is 0.
  - An in-flight sample is discarded with no output.
- Throughput: one sample per NUM_CLASSES*CLAUSES_PER_CLASS+2 cycles with out_ready held high.

Test Plan:
1. Default masks: after rst, features=2'b01 → latency 8, class_out=0, best_vote=0 (all votes tie at 0; lowest index wins).
2. Load class0 j0..j3 = 1100, 1100, 1001, 0110 and class1 j0..j3 = 0101, 0001, 1100, 0011:
   - features=00 → votes +2/−1, class_out=0, best_vote=2.
   - features=01 → −1/0, class_out=1, best_vote=0.
   - features=11 → 0/−1, class_out=0, best_vote=0.
   - features=10 → −1/0, class_out=1, best_vote=0.
3. Back-pressure: with the test-2 masks, hold out_ready=0 for 5 cycles with features=00 → out_valid, class_out and best_vote stay stable; in_ready stays 0; a second in_valid is not accepted until the cycle after the out_ready handshake.
4. cfg_we writing class0 j0=0000 at cycle 3 of EVAL → current result unchanged (matches the test-2 value); a readback inference then shows the new mask in effect.
5. Assert rst at EVAL cycle 4 → out_valid never rises for that sample; in_ready=1 the next cycle; masks revert to all-ones (scenario 1 result).
6. Back-to-back: 4 samples with in_valid and out_ready tied high → one result every 10 cycles, in order.
